// File: rtl/vendor_specific_infoframe_parser.sv
// Sink-side Vendor-Specific InfoFrame parser: filters HB0==VSIF_TYPE packets from a byte stream,
// verifies the 8-bit checksum and publishes OUI / HF version / ALLM / HDMI_VIC of good frames.
module vendor_specific_infoframe_parser #(
  parameter logic [7:0] VSIF_TYPE  = 8'h81,
  parameter logic [4:0] MAX_LENGTH = 5'd27
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [7:0]  in_byte,
  output logic        frame_valid,
  output logic        checksum_error,
  output logic        length_error,
  output logic [23:0] oui,
  output logic [7:0]  hf_version,
  output logic        allm,
  output logic [7:0]  hdmi_vic,
  output logic [7:0]  frame_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SKIP  = 3'd1;
  localparam logic [2:0] HDR   = 3'd2;
  localparam logic [2:0] BODY  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  localparam logic [4:0] LAST_SKIP_CNT = 5'd30;  // 31st byte of a skipped packet ends it
  localparam logic [4:0] LAST_PB_IDX   = 5'd27;
  localparam logic [23:0] OUI_HF   = 24'hC45DD8;
  localparam logic [23:0] OUI_HDMI = 24'h000C03;

  logic [2:0] state;
  logic [4:0] cnt;
  logic [4:0] idx;
  logic [7:0] sum;
  logic [7:0] hb2;
  logic [7:0] pb1, pb2, pb3, pb4, pb5;

  wire [23:0] shadow_oui = {pb3, pb2, pb1};

  // NOTE: shadow registers and byte counters are cleared on reset too, so a reset mid-packet
  // leaves no stale header or partial sum that a later frame could inherit.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      sum            <= '0;
      hb2            <= '0;
      pb1            <= '0;
      pb2            <= '0;
      pb3            <= '0;
      pb4            <= '0;
      pb5            <= '0;
      frame_valid    <= 1'b0;
      checksum_error <= 1'b0;
      length_error   <= 1'b0;
      oui            <= '0;
      hf_version     <= '0;
      allm           <= 1'b0;
      hdmi_vic       <= '0;
      frame_count    <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
      frame_valid    <= 1'b0;
      checksum_error <= 1'b0;
      length_error   <= 1'b0;

      if (state == CHECK) begin
        state <= IDLE;
        if (hb2[4:0] > MAX_LENGTH) begin
          length_error <= 1'b1;
        end else if (sum != 8'h00) begin
          checksum_error <= 1'b1;
        end else begin
          frame_valid <= 1'b1;
          frame_count <= frame_count + 8'd1;
          oui         <= shadow_oui;
          hf_version  <= pb4;
          allm        <= (shadow_oui == OUI_HF) ? pb5[1] : 1'b0;
          hdmi_vic    <= (shadow_oui == OUI_HDMI && pb4[7:5] == 3'b001) ? pb5 : 8'h00;
        end
      end else if (in_valid) begin
        if (in_sop) begin
          // A start-of-packet restarts parsing from any state, abandoning the current packet.
          sum   <= in_byte;
          cnt   <= 5'd1;
          state <= (in_byte == VSIF_TYPE) ? HDR : SKIP;
        end else begin
          case (state)
            SKIP: begin
              cnt <= cnt + 5'd1;
              if (cnt == LAST_SKIP_CNT) state <= IDLE;
            end
            HDR: begin
              sum <= sum + in_byte;
              if (cnt == 5'd1) begin
                cnt <= 5'd2;
              end else begin
                hb2   <= in_byte;
                idx   <= '0;
                state <= BODY;
              end
            end
            BODY: begin
              // Padding beyond PB[HB2] is consumed but kept out of the checksum.
              if (idx <= hb2[4:0]) sum <= sum + in_byte;
              case (idx)
                5'd1:    pb1 <= in_byte;
                5'd2:    pb2 <= in_byte;
                5'd3:    pb3 <= in_byte;
                5'd4:    pb4 <= in_byte;
                5'd5:    pb5 <= in_byte;
                default: ;
              endcase
              if (idx == LAST_PB_IDX) state <= CHECK;
              else                    idx   <= idx + 5'd1;
            end
            default: ;  // IDLE without in_sop: byte discarded
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vendor_specific_infoframe_parser.sv
// Directed bench for vendor_specific_infoframe_parser: hand-computed frames and expected fields.
module tb_vendor_specific_infoframe_parser;

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_sop    = 1'b0;
  logic [7:0]  in_byte   = 8'h00;
  logic        frame_valid, checksum_error, length_error, allm;
  logic [23:0] oui;
  logic [7:0]  hf_version, hdmi_vic, frame_count;

  vendor_specific_infoframe_parser dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_byte        (in_byte),
    .frame_valid    (frame_valid),
    .checksum_error (checksum_error),
    .length_error   (length_error),
    .oui            (oui),
    .hf_version     (hf_version),
    .allm           (allm),
    .hdmi_vic       (hdmi_vic),
    .frame_count    (frame_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0, ce_cnt = 0, le_cnt = 0;
  int fv0, ce0, le0;
  bit multi_hot = 1'b0;

  // Pulse monitor samples on the falling edge, away from the active edge.
  always @(negedge clk_pixel) begin
    if (frame_valid)    fv_cnt++;
    if (checksum_error) ce_cnt++;
    if (length_error)   le_cnt++;
    if ($countones({frame_valid, checksum_error, length_error}) > 1) multi_hot = 1'b1;
  end

  logic [7:0] frm [31];

  task automatic make_frame(input logic [7:0] hb0, hb2, p0, p1, p2, p3, p4, p5);
    frm[0] = hb0; frm[1] = 8'h01; frm[2] = hb2;
    frm[3] = p0; frm[4] = p1; frm[5] = p2; frm[6] = p3; frm[7] = p4; frm[8] = p5;
    for (int i = 9; i < 31; i++) frm[i] = 8'h00;
  endtask

  task automatic make_allm();
    make_frame(8'h81, 8'h05, 8'h7D, 8'hD8, 8'h5D, 8'hC4, 8'h01, 8'h02);
  endtask

  task automatic tick();
    @(posedge clk_pixel); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop, input bit gap);
    in_valid = 1'b1; in_sop = sop; in_byte = b;
    tick();
    in_valid = 1'b0; in_sop = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_range(input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) send_byte(frm[i], i == 0, gap);
  endtask

  task automatic window_start();
    fv0 = fv_cnt; ce0 = ce_cnt; le0 = le_cnt;
  endtask

  // Lets CHECK complete and the pulse be sampled before counts are compared.
  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic check_pulses(input string name, input int efv, ece, ele);
    checks++;
    if ((fv_cnt - fv0) !== efv || (ce_cnt - ce0) !== ece || (le_cnt - le0) !== ele) begin
      errors++;
      $display("FAIL %s pulses: got fv=%0d ce=%0d le=%0d, want fv=%0d ce=%0d le=%0d", name,
               fv_cnt - fv0, ce_cnt - ce0, le_cnt - le0, efv, ece, ele);
    end
  endtask

  task automatic check_fields(input string name, input logic [23:0] e_oui, input logic [7:0] e_hf,
                              input logic e_allm, input logic [7:0] e_vic, input logic [7:0] e_cnt);
    checks++;
    if (oui !== e_oui || hf_version !== e_hf || allm !== e_allm || hdmi_vic !== e_vic ||
        frame_count !== e_cnt) begin
      errors++;
      $display("FAIL %s fields: got oui=%h hf=%h allm=%b vic=%h cnt=%0d, want oui=%h hf=%h allm=%b vic=%h cnt=%0d",
               name, oui, hf_version, allm, hdmi_vic, frame_count, e_oui, e_hf, e_allm, e_vic, e_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({frame_valid, checksum_error, length_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b, want 000", {frame_valid, checksum_error, length_error});
    end
    check_fields("reset", 24'h0, 8'h00, 1'b0, 8'h00, 8'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_allm();
    make_allm();
    window_start();
    send_range(0, 30, 1'b0);
    // Pulse must appear within a couple of cycles of the last byte.
    repeat (3) begin
      @(negedge clk_pixel);
    end
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL allm_latency: got %0d pulses within 3 cycles, want 1", fv_cnt - fv0);
    end
    settle();
    check_pulses("allm", 1, 0, 0);
    check_fields("allm", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd1);
  endtask

  task automatic test_bad_checksum();
    make_allm();
    frm[3] = 8'h7E;
    window_start();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("bad_checksum", 0, 1, 0);
    check_fields("bad_checksum", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd1);
  endtask

  task automatic test_hdmi_vic();
    make_frame(8'h81, 8'h05, 8'h49, 8'h03, 8'h0C, 8'h00, 8'h20, 8'h01);
    window_start();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("hdmi_vic", 1, 0, 0);
    check_fields("hdmi_vic", 24'h000C03, 8'h20, 1'b0, 8'h01, 8'd2);
  endtask

  task automatic test_non_vsif();
    make_allm();
    frm[0] = 8'h82;
    window_start();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("non_vsif", 0, 0, 0);
    // A stray byte with in_sop low while idle must be ignored.
    send_byte(8'h81, 1'b0, 1'b0);
    make_allm();
    window_start();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("after_non_vsif", 1, 0, 0);
    check_fields("after_non_vsif", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd3);
  endtask

  task automatic test_length_and_gaps();
    make_allm();
    frm[2] = 8'h1F;
    window_start();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("length", 0, 0, 1);
    check_fields("length", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd3);
    make_allm();
    window_start();
    send_range(0, 30, 1'b1);
    settle();
    check_pulses("gapped", 1, 0, 0);
    check_fields("gapped", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd4);
  endtask

  task automatic test_sop_abort();
    make_frame(8'h81, 8'h05, 8'h49, 8'h03, 8'h0C, 8'h00, 8'h20, 8'h01);
    window_start();
    send_range(0, 12, 1'b0);  // HB0..PB9; the next in_sop lands where PB10 would be
    make_allm();
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("sop_abort", 1, 0, 0);
    check_fields("sop_abort", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd5);
  endtask

  task automatic test_reset_mid();
    make_allm();
    window_start();
    send_range(0, 22, 1'b0);  // HB0..PB19
    reset = 1'b1;
    send_byte(frm[23], 1'b0, 1'b0);
    reset = 1'b0;
    send_range(24, 30, 1'b0);
    settle();
    check_pulses("reset_mid", 0, 0, 0);
    check_fields("reset_mid", 24'h0, 8'h00, 1'b0, 8'h00, 8'd0);
  endtask

  task automatic test_back_to_back_wrap();
    make_allm();
    window_start();
    for (int n = 0; n < 255; n++) begin
      send_range(0, 30, 1'b0);
      tick();
    end
    settle();
    check_fields("wrap_255", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd255);
    send_range(0, 30, 1'b0);
    settle();
    check_pulses("wrap", 256, 0, 0);
    check_fields("wrap_0", 24'hC45DD8, 8'h01, 1'b1, 8'h00, 8'd0);
  endtask

  initial begin
    test_reset();
    test_allm();
    test_bad_checksum();
    test_hdmi_vic();
    test_non_vsif();
    test_length_and_gaps();
    test_sop_abort();
    test_reset_mid();
    test_back_to_back_wrap();
    checks++;
    if (multi_hot !== 1'b0) begin
      errors++;
      $display("FAIL one_hot_pulses: got overlap=%b, want 0", multi_hot);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
